register_bank_decode: RTL and testbench
=======================================

Name: register_bank_decode

Overview:
- 16-entry general-purpose register file; the consuming end of the one-hot register-select vectors produced by the operand select/encode stage.
- Decodes the one-hot R_In vector into a clocked write of bus data, and the one-hot R_Out vector into a bus-source read.
- Applies the BAOut rule: register 0 reads as zero when BAOut is asserted.
- Polices the one-hot contract with a sticky error flag and a capture of the first offending vector.

Parameters:
- DATA_W, 32, register and bus width
- NUM_REGS, 16, register count; must equal the R_In/R_Out vector width
- RESET_VAL, 0, value loaded into every register on clear

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- clear  in  1  synchronous, active-high reset
- R_In  in  NUM_REGS  one-hot write-enable vector
- R_Out  in  NUM_REGS  one-hot read-select vector
- BAOut  in  1  base-address read; forces register 0 to read as zero
- BusMuxOut  in  DATA_W  bus value to be written
- RegData  out  DATA_W  selected register value driven toward the bus mux
- RegSel  out  1  high when RegData is a valid register source (exactly one R_Out bit set)
- onehot_err  out  1  sticky: a multi-hot R_In or R_Out vector was seen
- err_vec  out  2*NUM_REGS  {R_In,R_Out} captured on the first error
- last_wr_idx  out  4  index of the most recent committed write

Behaviour:
- Reset:
  - Clock and reset are fixed: a single clock `clock`; `clear` is synchronous, active-high, sampled on the rising edge of `clock`.
  - With clear=1 at an edge: all registers load RESET_VAL; onehot_err=0; err_vec=0; last_wr_idx=0.
  - clear has priority over writes in the same cycle.
- Write path:
  - At a rising edge, if R_In has exactly one bit k set: reg[k] <= BusMuxOut and last_wr_idx <= k.
  - R_In all-zero: no state change.
  - R_In with two or more bits set: no register is written, last_wr_idx is held, and the error path fires.
- Read path (combinational, zero latency):
  - Exactly one R_Out bit k set: RegData=reg[k], RegSel=1.
  - Exception: if k==0 and BAOut=1, then RegData=0 and RegSel=1.
  - R_Out all-zero or multi-hot: RegData=0, RegSel=0.
  - BAOut with any k other than 0 has no effect on the read.
- Read/write same register, same cycle: RegData shows the pre-edge (old) value. The new value is visible in the cycle after the edge, unless BYPASS_EN is defined.
- Error path:
  - At an edge with clear=0, onehot_err <= 1 if popcount(R_In)>1 or popcount(R_Out)>1.
  - On the first such edge (onehot_err was 0), err_vec <= {R_In,R_Out}.
  - Later errors leave err_vec unchanged; only clear clears either output.
- Register 0 is a normal storage register; only reads with BAOut are zeroed. A write to index 0 always stores the value.
- No state machine beyond the error latch (IDLE -> ERR on first violation, ERR -> IDLE only on clear).

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined: when the R_In and R_Out one-hot indices are equal and both valid, RegData=BusMuxOut in the same cycle (write-through). The BAOut zero rule still wins for index 0.
- Undefined: RegData always reflects stored contents (old value during a same-cycle write).

Decomposition:
- Shared package regbank_pkg holds:
  - constants NUM_REGS=16 and REG_IDX_W=4, and typedef reg_idx_t
  - functions onehot_count (popcount capped at 2) and onehot_valid
- Sub-module onehot_to_index: NUM_REGS-bit vector in; REG_IDX_W index plus valid out (valid = exactly one bit set). Instantiated twice, for the R_In and R_Out paths.

Test Plan:
1. Clear, then R_In=16'h0008 with BusMuxOut=32'hDEADBEEF for one edge; then R_Out=16'h0008 -> RegData=32'hDEADBEEF, RegSel=1, last_wr_idx=3.
2. Write 32'h00000055 to R0; then R_Out=16'h0001 with BAOut=1 -> RegData=0; same select with BAOut=0 -> RegData=32'h00000055.
3. R_In=16'h0011 with BusMuxOut=32'h12345678 -> R0/R4 unchanged, onehot_err=1, err_vec={16'h0011,16'h0000}; a later R_Out=16'h0300 leaves err_vec unchanged.
4. R_In=R_Out=16'h0020, old R5=32'h1, BusMuxOut=32'h2 -> RegData=32'h1 before the edge, 32'h2 after. With REGBANK_BYPASS_EN: RegData=32'h2 before the edge.
5. Assert clear in the same cycle as R_In=16'h8000, BusMuxOut=32'hFFFFFFFF -> R15=0, onehot_err=0, last_wr_idx=0. Then R_Out=16'h0000 -> RegSel=0, RegData=0.

Source files
------------

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants, index type, error-latch states and one-hot helpers for the register bank.
package regbank_pkg;
  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef enum logic {ERR_IDLE, ERR_SEEN} err_state_t;
  // Population count saturating at 2: callers only need to tell none, one and many apart.
  function automatic logic [1:0] onehot_count(input logic [NUM_REGS-1:0] v);
    logic [1:0] c;
    c = 2'd0;
    for (int i = 0; i < NUM_REGS; i++)
      if (v[i] && c != 2'd2) c = c + 2'd1;
    return c;
  endfunction
  function automatic logic onehot_valid(input logic [NUM_REGS-1:0] v);
    return onehot_count(v) == 2'd1;
  endfunction
endpackage

// File: rtl/register_bank_decode_onehot_to_index.sv
// onehot_to_index: converts a NUM_REGS-bit select vector to a binary index.
//   i_vec   - select vector
//   o_idx   - index of the set bit (meaningful only when o_valid)
//   o_valid - exactly one bit of i_vec is set
module onehot_to_index
  import regbank_pkg::*;
(
  input  logic [NUM_REGS-1:0] i_vec,
  output reg_idx_t            o_idx,
  output logic                o_valid
);
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (i_vec[i]) o_idx = REG_IDX_W'(i);
  end
  assign o_valid = onehot_valid(i_vec);
endmodule

// File: rtl/register_bank_decode.sv
// register_bank_decode: 16-entry register file driven by one-hot write/read select vectors.
//   clock, clear   - clock and synchronous active-high clear
//   R_In           - one-hot write enable; BusMuxOut is stored into the selected register
//   R_Out          - one-hot read select; drives RegData/RegSel combinationally
//   BAOut          - forces a register 0 read to return zero
//   onehot_err     - sticky flag for any multi-hot R_In/R_Out
//   err_vec        - {R_In,R_Out} captured at the first violation
//   last_wr_idx    - index of the most recent committed write
// Build option REGBANK_BYPASS_EN: same-index read during a write returns BusMuxOut (write-through).
module register_bank_decode
  import regbank_pkg::*;
#(
  parameter int                  DATA_W    = 32,
  parameter int                  NUM_REGS  = 16,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [NUM_REGS-1:0]     R_In,
  input  logic [NUM_REGS-1:0]     R_Out,
  input  logic                    BAOut,
  input  logic [DATA_W-1:0]       BusMuxOut,
  output logic [DATA_W-1:0]       RegData,
  output logic                    RegSel,
  output logic                    onehot_err,
  output logic [2*NUM_REGS-1:0]   err_vec,
  output logic [3:0]              last_wr_idx
);
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  err_state_t          r_state;
  logic [2*NUM_REGS-1:0] r_err_vec;
  reg_idx_t            r_last;
  reg_idx_t            w_wr_idx;
  reg_idx_t            w_rd_idx;
  logic                w_wr_vld;
  logic                w_rd_vld;
  logic                w_multi;
  logic [DATA_W-1:0]   w_src;
  onehot_to_index u_wr (.i_vec(R_In),  .o_idx(w_wr_idx), .o_valid(w_wr_vld));
  onehot_to_index u_rd (.i_vec(R_Out), .o_idx(w_rd_idx), .o_valid(w_rd_vld));
  assign w_multi = onehot_count(R_In) == 2'd2 || onehot_count(R_Out) == 2'd2;
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
      r_state   <= ERR_IDLE;
      r_err_vec <= '0;
      r_last    <= '0;
    end else begin
      if (w_wr_vld) begin
        r_regs[w_wr_idx] <= BusMuxOut;
        r_last           <= w_wr_idx;
      end
      // Error latch leaves only on clear; err_vec keeps the first offender.
      if (w_multi) begin
        r_state <= ERR_SEEN;
        if (r_state == ERR_IDLE) r_err_vec <= {R_In, R_Out};
      end
    end
  end
`ifdef REGBANK_BYPASS_EN
  assign w_src = (w_wr_vld && w_wr_idx == w_rd_idx) ? BusMuxOut : r_regs[w_rd_idx];
`else
  assign w_src = r_regs[w_rd_idx];
`endif
  assign RegData     = (!w_rd_vld || (w_rd_idx == '0 && BAOut)) ? '0 : w_src;
  assign RegSel      = w_rd_vld;
  assign onehot_err  = r_state == ERR_SEEN;
  assign err_vec     = r_err_vec;
  assign last_wr_idx = r_last;
endmodule

// File: tb/tb_register_bank_decode.sv
// tb_register_bank_decode: scoreboard bench with directed plan steps and random select traffic.
module tb_register_bank_decode;
  typedef struct {
    logic [31:0] data;
    logic        sel;
    logic        err;
    logic [31:0] ev;
    logic [3:0]  last;
  } exp_t;
  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [15:0] R_In = '0, R_Out = '0;
  logic        BAOut = 1'b0;
  logic [31:0] BusMuxOut = '0;
  logic [31:0] RegData;
  logic        RegSel;
  logic        onehot_err;
  logic [31:0] err_vec;
  logic [3:0]  last_wr_idx;
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_regs [16];
  logic        m_err;
  logic [31:0] m_ev;
  logic [3:0]  m_last;
  register_bank_decode dut (
    .clock(clock), .clear(clear), .R_In(R_In), .R_Out(R_Out), .BAOut(BAOut),
    .BusMuxOut(BusMuxOut), .RegData(RegData), .RegSel(RegSel),
    .onehot_err(onehot_err), .err_vec(err_vec), .last_wr_idx(last_wr_idx)
  );
  always #5 clock = ~clock;
  function automatic int pos(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("RegData", RegData, e.data);
      chk("RegSel", 32'(RegSel), 32'(e.sel));
      chk("onehot_err", 32'(onehot_err), 32'(e.err));
      chk("err_vec", err_vec, e.ev);
      chk("last_wr_idx", 32'(last_wr_idx), 32'(e.last));
    end
  end
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_err = 1'b0;
    m_ev = '0;
    m_last = '0;
  endtask
  task automatic cyc(input logic clr, input logic [15:0] rin, input logic [15:0] rout,
                     input logic ba, input logic [31:0] bus);
    exp_t e;
    @(posedge clock);
    #1;
    clear = clr; R_In = rin; R_Out = rout; BAOut = ba; BusMuxOut = bus;
    e.sel = $countones(rout) == 1;
    e.data = e.sel ? m_regs[pos(rout)] : 32'h0;
`ifdef REGBANK_BYPASS_EN
    if (e.sel && $countones(rin) == 1 && pos(rin) == pos(rout)) e.data = bus;
`endif
    if (e.sel && pos(rout) == 0 && ba) e.data = 32'h0;
    e.err = m_err;
    e.ev = m_ev;
    e.last = m_last;
    sb.push_back(e);
    if (clr) model_reset();
    else begin
      if ($countones(rin) == 1) begin
        m_regs[pos(rin)] = bus;
        m_last = 4'(pos(rin));
      end
      if ($countones(rin) > 1 || $countones(rout) > 1) begin
        if (!m_err) m_ev = {rin, rout};
        m_err = 1'b1;
      end
    end
  endtask
  function automatic logic [15:0] rand_sel();
    int r;
    r = $urandom_range(0, 9);
    return r == 0 ? 16'h0 : r == 1 ? 16'($urandom) : 16'h1 << $urandom_range(0, 15);
  endfunction
  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    cyc(0, 16'h0, 16'h0, 0, 32'h0);
    cyc(0, 16'h0008, 16'h0, 0, 32'hDEADBEEF);
    cyc(0, 16'h0, 16'h0008, 0, 32'h0);
    cyc(0, 16'h0001, 16'h0, 0, 32'h00000055);
    cyc(0, 16'h0, 16'h0001, 1, 32'h0);
    cyc(0, 16'h0, 16'h0001, 0, 32'h0);
    cyc(0, 16'h0020, 16'h0, 0, 32'h1);
    cyc(0, 16'h0020, 16'h0020, 0, 32'h2);
    cyc(0, 16'h0, 16'h0020, 0, 32'h0);
    cyc(0, 16'h0, 16'h0020, 1, 32'h0);
    cyc(0, 16'h0011, 16'h0, 0, 32'h12345678);
    cyc(0, 16'h0, 16'h0001, 0, 32'h0);
    cyc(0, 16'h0, 16'h0010, 0, 32'h0);
    cyc(0, 16'h0, 16'h0300, 0, 32'h0);
    cyc(0, 16'h0, 16'h0, 0, 32'h0);
    cyc(1, 16'h8000, 16'h0, 0, 32'hFFFFFFFF);
    cyc(0, 16'h0, 16'h8000, 0, 32'h0);
    cyc(0, 16'h0, 16'h0, 0, 32'h0);
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 29) == 0, rand_sel(), rand_sel(), 1'($urandom), $urandom);
    cyc(0, 16'h0, 16'h0, 0, 32'h0);
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clock);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
